// File: rtl/fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fg_prog_sequencer
// Brief   : Settle/pulse/release programming sequencer for one floating-gate
//           island. Readback (read op, SAMPLE state) needs FGPROG_READBACK_EN.
// Revision: 1.0
// ============================================================================
module fg_prog_sequencer #(
  parameter int ROWS    = 5,
  parameter int COLS    = 4,
  parameter int ROW_W   = 3,
  parameter int COL_W   = 2,
  parameter int CNT_W   = 8,
  parameter int SETTLE  = 4,
  parameter int PULSE_W = 16,
  parameter int GAP_W   = 4,
  parameter int DATA_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [COL_W-1:0]  cmd_col,
  input  logic [CNT_W-1:0]  cmd_pulses,
  input  logic              abort,
  output logic [ROW_W-1:0]  row_sel,
  output logic [COL_W-1:0]  col_sel,
  output logic              drain_sel,
  output logic              prog_en,
  output logic              vinj_pulse,
  output logic              tun_pulse,
  input  logic [DATA_W-1:0] meas_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_PULSE   = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
`ifdef FGPROG_READBACK_EN
  localparam logic [2:0] S_SAMPLE  = 3'd4;
  localparam logic [1:0] OP_READ   = 2'b10;
`endif
  localparam logic [1:0] OP_INJ    = 2'b00;
  localparam logic [1:0] OP_TUN    = 2'b01;

  localparam int TMR_MAX_A = (SETTLE > PULSE_W) ? SETTLE : PULSE_W;
  localparam int TMR_MAX   = (TMR_MAX_A > GAP_W) ? TMR_MAX_A : GAP_W;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] T_PULSE  = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] T_GAP    = TMR_W'(GAP_W - 1);
  localparam logic [ROW_W:0]   ROWS_L   = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]   COLS_L   = (COL_W+1)'(COLS);

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [ROW_W-1:0]  row_sel_q, row_sel_d;
  logic [COL_W-1:0]  col_sel_q, col_sel_d;
  logic              drain_sel_q, drain_sel_d;
  logic              prog_en_q, prog_en_d;
  logic              vinj_q, vinj_d;
  logic              tun_q, tun_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              accept_ok, accept_bad, cmd_legal, drive;

  always_comb begin
    cmd_legal = (cmd_op == OP_INJ) || (cmd_op == OP_TUN);
`ifdef FGPROG_READBACK_EN
    cmd_legal = cmd_legal || (cmd_op == OP_READ);
`endif
    cmd_legal = cmd_legal && ({1'b0, cmd_row} < ROWS_L) && ({1'b0, cmd_col} < COLS_L);
  end

  // State register; outputs are registered from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      row_sel_q   <= '0;
      col_sel_q   <= '0;
      drain_sel_q <= 1'b0;
      prog_en_q   <= 1'b0;
      vinj_q      <= 1'b0;
      tun_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      row_sel_q   <= row_sel_d;
      col_sel_q   <= col_sel_d;
      drain_sel_q <= drain_sel_d;
      prog_en_q   <= prog_en_d;
      vinj_q      <= vinj_d;
      tun_q       <= tun_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    accept_ok  = 1'b0;
    accept_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_legal) begin
            accept_ok = 1'b1;
            state_d   = S_SETUP;
            timer_d   = T_SETTLE;
            cnt_d     = cmd_pulses;
            op_d      = cmd_op;
          end else begin
            accept_bad = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_RELEASE;
          timer_d = T_SETTLE;
        end else if (timer_q == '0) begin
          if (cnt_q == '0) begin
            state_d = S_RELEASE;
            timer_d = T_SETTLE;
          end else begin
            state_d = S_PULSE;
            timer_d = T_PULSE;
          end
`ifdef FGPROG_READBACK_EN
          if (op_q == OP_READ) state_d = S_SAMPLE;
`endif
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_d = S_RELEASE;
          timer_d = T_SETTLE;
        end else if (timer_q == '0) begin
          state_d = S_GAP;
          timer_d = T_GAP;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (abort || (timer_q == '0 && cnt_q == '0)) begin
          state_d = S_RELEASE;
          timer_d = T_SETTLE;
        end else if (timer_q == '0) begin
          state_d = S_PULSE;
          timer_d = T_PULSE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
`ifdef FGPROG_READBACK_EN
      S_SAMPLE: begin
        state_d = S_RELEASE;
        timer_d = T_SETTLE;
      end
`endif
      S_RELEASE: begin
        if (timer_q == '0) state_d = S_DONE;
        else timer_d = timer_q - TMR_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // op_d[1] is only ever set for a latched read, which never drives prog_en.
  always_comb begin
    drive       = (state_d != S_IDLE) && (state_d != S_RELEASE) && (state_d != S_DONE);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    drain_sel_d = drive;
    prog_en_d   = drive && !op_d[1];
    vinj_d      = (state_d == S_PULSE) && (op_d == OP_INJ);
    tun_d       = (state_d == S_PULSE) && (op_d == OP_TUN);
    done_d      = (state_d == S_DONE);
    err_d       = accept_bad;
    row_sel_d   = row_sel_q;
    col_sel_d   = col_sel_q;
    if (accept_ok) begin
      row_sel_d = cmd_row;
      col_sel_d = cmd_col;
    end else if (state_d == S_DONE) begin
      row_sel_d = '0;
      col_sel_d = '0;
    end
  end

`ifdef FGPROG_READBACK_EN
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // An aborted SAMPLE neither captures nor flags a measurement.
  always_comb begin
    rd_valid_d = (state_q == S_SAMPLE) && !abort;
    rd_data_d  = rd_valid_d ? meas_in : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_meas;
  assign unused_meas = ^meas_in;
  assign rd_data     = '0;
  assign rd_valid    = 1'b0;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign row_sel    = row_sel_q;
  assign col_sel    = col_sel_q;
  assign drain_sel  = drain_sel_q;
  assign prog_en    = prog_en_q;
  assign vinj_pulse = vinj_q;
  assign tun_pulse  = tun_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fg_prog_sequencer
// Brief   : Directed cycle-accurate bench for fg_prog_sequencer.
// Revision: 1.0
// ============================================================================
module tb_fg_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_row = '0;
  logic [1:0] cmd_col = '0;
  logic [7:0] cmd_pulses = '0;
  logic       abort = 1'b0;
  logic [2:0] row_sel;
  logic [1:0] col_sel;
  logic       drain_sel, prog_en, vinj_pulse, tun_pulse;
  logic [9:0] meas_in = '0;
  logic [9:0] rd_data;
  logic       rd_valid, done, err, busy;

  int tests = 0;
  int fails = 0;

  fg_prog_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_pulses(cmd_pulses),
    .abort(abort), .row_sel(row_sel), .col_sel(col_sel), .drain_sel(drain_sel),
    .prog_en(prog_en), .vinj_pulse(vinj_pulse), .tun_pulse(tun_pulse),
    .meas_in(meas_in), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // {ready, drain, prog, vinj, tun, done, err, busy, rd_valid, row[2:0], col[1:0]}
  function automatic logic [13:0] obs();
    return {cmd_ready, drain_sel, prog_en, vinj_pulse, tun_pulse, done, err, busy,
            rd_valid, row_sel, col_sel};
  endfunction

  function automatic logic [13:0] mk(input bit rdy, input bit drn, input bit prg,
                                     input bit vj, input bit tn, input bit dn,
                                     input bit er, input bit bs, input bit rv,
                                     input int row, input int col);
    logic [2:0] r;
    logic [1:0] c;
    r = 3'(row);
    c = 2'(col);
    return {rdy, drn, prg, vj, tn, dn, er, bs, rv, r, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the acceptance edge (cycle 1).
  task automatic issue(input logic [1:0] op, input logic [2:0] row,
                       input logic [1:0] col, input logic [7:0] n);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_op = op; cmd_row = row; cmd_col = col; cmd_pulses = n;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    tests++;
    if (obs() !== 14'd0 || rd_data !== 10'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%b rd=%h expected all zero", obs(), rd_data);
    end
    rst = 1'b0;
    step();
    tests++;
    if (obs() !== mk(1,0,0,0,0,0,0,0,0,0,0)) begin
      fails++;
      $display("FAIL reset_idle got=%b expected=%b", obs(), mk(1,0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_inject();
    logic [13:0] e;
    bit act, p;
    issue(2'b00, 3'd2, 2'd1, 8'd3);
    for (int cyc = 1; cyc <= 70; cyc++) begin
      act = (cyc <= 64);
      p = (cyc >= 5) && (cyc <= 64) && (((cyc - 5) % 20) < 16);
      e = mk(cyc == 70, act, act, p, 0, cyc == 69, 0, cyc <= 69, 0,
             (cyc <= 68) ? 2 : 0, (cyc <= 68) ? 1 : 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL inject cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      step();
    end
  endtask

  // Abort while in RELEASE must be ignored.
  task automatic test_tunnel_zero();
    logic [13:0] e;
    bit act;
    issue(2'b01, 3'd4, 2'd3, 8'd0);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      abort = (cyc == 6);
      act = (cyc <= 4);
      e = mk(cyc == 10, act, act, 0, 0, cyc == 9, 0, cyc <= 9, 0,
             (cyc <= 8) ? 4 : 0, (cyc <= 8) ? 3 : 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL tunnel_zero cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      step();
    end
    abort = 1'b0;
  endtask

  task automatic test_read();
    logic [13:0] e;
    issue(2'b10, 3'd3, 2'd2, 8'd0);
`ifdef FGPROG_READBACK_EN
    for (int cyc = 1; cyc <= 11; cyc++) begin
      meas_in = (cyc == 5) ? 10'h2A5 : 10'h155;
      e = mk(cyc == 11, cyc <= 5, 0, 0, 0, cyc == 10, 0, cyc <= 10, cyc == 6,
             (cyc <= 9) ? 3 : 0, (cyc <= 9) ? 2 : 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL read cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      step();
    end
    tests++;
    if (rd_data !== 10'h2A5) begin
      fails++;
      $display("FAIL read_data got=%h expected=2a5", rd_data);
    end
`else
    for (int cyc = 1; cyc <= 2; cyc++) begin
      e = mk(1, 0, 0, 0, 0, 0, cyc == 1, 0, 0, 0, 0);
      tests++;
      if (obs() !== e || rd_data !== 10'd0) begin
        fails++;
        $display("FAIL read_rejected cyc=%0d got=%b rd=%h expected=%b rd=0", cyc, obs(), rd_data, e);
      end
      step();
    end
`endif
    meas_in = '0;
  endtask

  task automatic test_reject();
    logic [13:0] e;
    issue(2'b00, 3'd5, 2'd0, 8'd3);
    for (int cyc = 1; cyc <= 2; cyc++) begin
      e = mk(1, 0, 0, 0, 0, 0, cyc == 1, 0, 0, 0, 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL reject_row cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      step();
    end
    issue(2'b11, 3'd1, 2'd1, 8'd2);
    for (int cyc = 1; cyc <= 2; cyc++) begin
      e = mk(1, 0, 0, 0, 0, 0, cyc == 1, 0, 0, 0, 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL reject_op cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      step();
    end
  endtask

  // Abort sampled at the edge ending cycle 30 (mid 2nd pulse).
  task automatic test_abort();
    logic [13:0] e;
    bit act, p, prev;
    int rises;
    rises = 0;
    prev = 0;
    issue(2'b00, 3'd1, 2'd2, 8'd10);
    for (int cyc = 1; cyc <= 36; cyc++) begin
      abort = (cyc == 30);
      act = (cyc <= 30);
      p = (cyc >= 5 && cyc <= 20) || (cyc >= 25 && cyc <= 30);
      e = mk(cyc == 36, act, act, p, 0, cyc == 35, 0, cyc <= 35, 0,
             (cyc <= 34) ? 1 : 0, (cyc <= 34) ? 2 : 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL abort cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      if (vinj_pulse && !prev) rises++;
      prev = vinj_pulse;
      step();
    end
    abort = 1'b0;
    tests++;
    if (rises !== 2) begin
      fails++;
      $display("FAIL abort_pulse_count got=%0d expected=2", rises);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    bit act, p;
    issue(2'b00, 3'd3, 2'd0, 8'd5);
    for (int cyc = 1; cyc < 8; cyc++) step();
    tests++;
    if (vinj_pulse !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre vinj=%b expected 1", vinj_pulse);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (obs() !== 14'd0 || rd_data !== 10'd0) begin
      fails++;
      $display("FAIL reset_mid_async got=%b rd=%h expected all zero", obs(), rd_data);
    end
    step(); step();
    tests++;
    if (obs() !== 14'd0) begin
      fails++;
      $display("FAIL reset_mid_hold got=%b expected all zero", obs());
    end
    rst = 1'b0;
    step();
    issue(2'b01, 3'd4, 2'd3, 8'd1);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      act = (cyc <= 24);
      p = (cyc >= 5 && cyc <= 20);
      e = mk(cyc == 30, act, act, 0, p, cyc == 29, 0, cyc <= 29, 0,
             (cyc <= 28) ? 4 : 0, (cyc <= 28) ? 3 : 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL reset_mid_after cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      step();
    end
  endtask

  // Second command held valid; accepted on the edge ending cycle 30.
  task automatic test_back_to_back();
    logic [13:0] e;
    issue(2'b01, 3'd1, 2'd1, 8'd1);
    cmd_op = 2'b00; cmd_row = 3'd2; cmd_col = 2'd2; cmd_pulses = 8'd0;
    cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 31) cmd_valid = 1'b0;
      if (cyc <= 29)
        e = mk(0, cyc <= 24, cyc <= 24, 0, cyc >= 5 && cyc <= 20, cyc == 29, 0, 1, 0,
               (cyc <= 28) ? 1 : 0, (cyc <= 28) ? 1 : 0);
      else if (cyc == 30 || cyc == 40)
        e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else
        e = mk(0, cyc <= 34, cyc <= 34, 0, 0, cyc == 39, 0, 1, 0,
               (cyc <= 38) ? 2 : 0, (cyc <= 38) ? 2 : 0);
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got=%b expected=%b", cyc, obs(), e);
      end
      step();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_max_pulses();
    int rises, done_cyc, bad;
    bit prev;
    rises = 0; done_cyc = 0; bad = 0; prev = 0;
    issue(2'b00, 3'd0, 2'd0, 8'd255);
    for (int cyc = 1; cyc <= 5110; cyc++) begin
      if (vinj_pulse && !prev) rises++;
      prev = vinj_pulse;
      if (done && done_cyc == 0) done_cyc = cyc;
      if ((vinj_pulse && tun_pulse) || (vinj_pulse && !prog_en)) bad++;
      step();
    end
    tests++;
    if (rises !== 255) begin
      fails++;
      $display("FAIL max_pulses_count got=%0d expected=255", rises);
    end
    tests++;
    if (done_cyc !== 5109) begin
      fails++;
      $display("FAIL max_pulses_done got=%0d expected=5109", done_cyc);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL max_pulses_exclusive got=%0d bad cycles expected=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_inject();
    test_tunnel_zero();
    test_read();
    test_reject();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_max_pulses();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fg_prog_sequencer.md
# fg_prog_sequencer

Programming sequencer for one floating-gate island: accepts a single program/read command per handshake and drives the island's programming mux (row decoder, column decoder, drain-select, prog-switch enable, injection/tunnel pulse) through a fixed settle, pulse and release sequence. It sits directly upstream of the island's VinjDecode, drainSelect and FourTgate prog-switch tiles, and downstream of the host command FIFO.

## Interface
Parameters:
- ROWS, 5, number of matrix rows in the island; valid row addresses are 0..ROWS-1
- COLS, 4, number of programmable columns; valid column addresses are 0..COLS-1
- ROW_W, 3, row address width
- COL_W, 2, column address width
- CNT_W, 8, pulse-count width
- SETTLE, 4, settle cycles after switch apply and after release (≥1)
- PULSE_W, 16, high cycles per programming pulse (≥1)
- GAP_W, 4, low cycles after each pulse (≥1)
- DATA_W, 10, measurement width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 inject, 01 tunnel, 10 read, 11 reserved
- cmd_row  in  ROW_W  target row
- cmd_col  in  COL_W  target column
- cmd_pulses  in  CNT_W  number of pulses
- abort  in  1  terminate the active command
- row_sel  out  ROW_W  row decoder bits
- col_sel  out  COL_W  column decoder bits
- drain_sel  out  1  drain-select enable
- prog_en  out  1  prog-switch enable
- vinj_pulse  out  1  injection pulse
- tun_pulse  out  1  tunnel pulse
- meas_in  in  DATA_W  measured drain value from the island
- rd_data  out  DATA_W  captured measurement
- rd_valid  out  1  rd_data updated (1 cycle)
- done  out  1  command complete (1 cycle)
- err  out  1  command rejected (1 cycle)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, SETUP, PULSE, GAP, SAMPLE, RELEASE, DONE.
- cmd_ready=1 only in IDLE. Acceptance on the edge where cmd_valid&&cmd_ready; the command is latched.
- Rejection: cmd_op=11, cmd_row≥ROWS, or cmd_col≥COLS. A rejected command pulses err in the cycle after acceptance and stays in IDLE. No switch output changes.
- SETUP: row_sel/col_sel take the latched address; drain_sel=1; prog_en=1 for inject/tunnel and prog_en=0 for read. The state lasts SETTLE cycles.
- After SETUP, inject/tunnel goes to PULSE if the pulse count is >0, otherwise to RELEASE. Read goes to SAMPLE.
- PULSE: vinj_pulse (inject) or tun_pulse (tunnel) is high for PULSE_W cycles. GAP then holds the pulse low for GAP_W cycles. After the last GAP, go to RELEASE; otherwise return to PULSE.
- SAMPLE (1 cycle): rd_data←meas_in; rd_valid pulses in the next cycle, together with the first RELEASE cycle.
- RELEASE: drain_sel, prog_en and both pulses are 0. row_sel/col_sel are held. The state lasts SETTLE cycles.
- DONE (1 cycle): done=1, row_sel/col_sel←0, then go to IDLE.
- abort in SETUP, PULSE, GAP or SAMPLE forces RELEASE on the next edge, and pulse outputs drop that edge. A SAMPLE aborted this way produces no rd_valid. abort in RELEASE, DONE or IDLE is ignored. done still pulses after an abort.
- Pulse counter: CNT_W bits, counts down, never wraps. cmd_pulses=255 yields exactly 255 pulses.
- vinj_pulse and tun_pulse are never high together, and neither is high while prog_en=0.

## Timing
- All outputs are registered.
- Reset values: every output is 0; rd_data=0; state=IDLE.
- Reset asserted mid-command drops all switch and pulse outputs asynchronously. No done is produced.
- Inject/tunnel with N pulses: done is high in cycle 2·SETTLE + N·(PULSE_W+GAP_W) + 1 after the acceptance edge. With defaults and N=2, that is cycle 49.
- Read: done is high in cycle 2·SETTLE + 2 after acceptance. meas_in is sampled in cycle SETTLE+1.
- Back-to-back: cmd_ready returns to 1 in the cycle after DONE. The minimum command spacing is therefore latency+1.
- Rejection: err is high in cycle 1 after acceptance; cmd_ready stays 1.

## Configuration
- FGPROG_READBACK_EN defined: the read op, SAMPLE state, rd_data and rd_valid are implemented.
- FGPROG_READBACK_EN undefined: cmd_op=10 is rejected with err like 11. rd_data and rd_valid are tied to 0, and meas_in is unused.

## Test plan
- Inject, row 2, col 1, 3 pulses (defaults) -> drain_sel/prog_en high from cycle 1. vinj_pulse has three 16-cycle highs starting at cycle 5 with 4-cycle gaps. done at cycle 69. row_sel=2 and col_sel=1 until DONE.
- Tunnel, 0 pulses -> no tun_pulse; done at cycle 9.
- Read, meas_in=0x2A5 (with macro) -> rd_data=0x2A5, rd_valid at cycle 6, done at cycle 10. Without the macro -> err at cycle 1 and no switch activity.
- cmd_row=5 or cmd_op=11 -> err at cycle 1, cmd_ready stays 1, all outputs 0.
- Inject, 10 pulses, abort in the middle of the 2nd pulse -> vinj_pulse low on the next edge. RELEASE lasts 4 cycles, then done. The pulse count stops at 2.
- rst asserted at pulse 1, cycle 8 -> all outputs 0 immediately. After release, the next command behaves normally from IDLE.
